// File: rtl/contador_163_param.sv
// 74163-style counter with generic width, programmable terminal value, up/down,
// wrap or saturate at terminal count, and a registered one-cycle end pulse.
module contador_163_param #(
   parameter int N      = 16,
   parameter bit SATURA = 1'b0
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         clr,
   input  logic         ld,
   input  logic         ent,
   input  logic         enp,
   input  logic         dir,
   input  logic [N-1:0] limite,
   input  logic [N-1:0] D,
   output logic [N-1:0] Q,
   output logic         rco,
   output logic         fim
);

   logic [N-1:0] q_q, q_d;
   logic         fim_q, fim_d;
   logic         saturado_q, saturado_d;
   logic         term, cen;

   // >= so a value loaded above limite still terminates on the next step
   assign term = dir ? (q_q == '0) : (q_q >= limite);
   assign cen  = ent & enp;
   assign rco  = ent & term;
   assign Q    = q_q;
   assign fim  = fim_q;

   always_comb begin
      q_d        = q_q;
      fim_d      = 1'b0;
      saturado_d = saturado_q & term;
      if (!clr) begin
         q_d        = '0;
         saturado_d = 1'b0;
      end else if (!ld) begin
         q_d        = D;
         saturado_d = 1'b0;
      end else if (cen && !term) begin
         q_d        = dir ? (q_q - N'(1)) : (q_q + N'(1));
         saturado_d = 1'b0;
      end else if (cen && term) begin
         if (!SATURA) begin
            q_d        = dir ? limite : '0;
            fim_d      = 1'b1;
            saturado_d = saturado_q;
         end else begin
            // pulse only on the first step attempted while parked at the terminal value
            fim_d      = ~saturado_q;
            saturado_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         q_q        <= '0;
         fim_q      <= 1'b0;
         saturado_q <= 1'b0;
      end else begin
         q_q        <= q_d;
         fim_q      <= fim_d;
         saturado_q <= saturado_d;
      end
   end

endmodule

// File: tb/tb_contador_163_param.sv
// Scoreboard bench: wrap and saturate instances share stimulus; a reference
// model predicts Q/fim per edge, a monitor pops and compares after each edge.
module tb_contador_163_param;

   localparam int N = 16;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         clr = 1'b1, ld = 1'b1, ent = 1'b0, enp = 1'b0, dir = 1'b0;
   logic [N-1:0] limite = '0, D = '0;
   logic [N-1:0] q0, q1;
   logic         rco0, rco1, fim0, fim1;

   int checks = 0;
   int failures = 0;

   typedef struct { int q0; int f0; int q1; int f1; } exp_t;
   exp_t sb[$];

   int m0 = 0, m1 = 0;
   bit s0 = 0, s1 = 0;

   contador_163_param #(.N(N), .SATURA(1'b0)) dut0 (
      .clock(clock), .reset(reset), .clr(clr), .ld(ld), .ent(ent), .enp(enp),
      .dir(dir), .limite(limite), .D(D), .Q(q0), .rco(rco0), .fim(fim0));

   contador_163_param #(.N(N), .SATURA(1'b1)) dut1 (
      .clock(clock), .reset(reset), .clr(clr), .ld(ld), .ent(ent), .enp(enp),
      .dir(dir), .limite(limite), .D(D), .Q(q1), .rco(rco1), .fim(fim1));

   always #5 clock = ~clock;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit is_term(input int m);
      return dir ? (m == 0) : (m >= int'(limite));
   endfunction

   // reference: one clock edge of the counter as described by the priority rules
   task automatic model(input bit sat_mode, input int m, input bit s,
                        output int mn, output bit sn, output bit fn);
      bit t;
      t  = is_term(m);
      mn = m; fn = 0; sn = s & t;
      if (!clr)      begin mn = 0; sn = 0; end
      else if (!ld)  begin mn = int'(D); sn = 0; end
      else if (ent && enp) begin
         if (!t)            begin mn = dir ? m - 1 : m + 1; sn = 0; end
         else if (!sat_mode) begin mn = dir ? int'(limite) : 0; fn = 1; sn = s; end
         else               begin fn = !s; sn = 1; end
      end
   endtask

   // apply inputs at negedge, check combinational rco, predict the next edge
   task automatic step(input bit c, input bit l, input bit et, input bit ep,
                       input bit dr, input int lim, input int d);
      int n0, n1;
      bit ns0, ns1, f0, f1;
      exp_t e;
      @(negedge clock);
      clr = c; ld = l; ent = et; enp = ep; dir = dr;
      limite = N'(lim); D = N'(d);
      #1;
      chk("rco_wrap", int'(rco0), int'(ent && is_term(m0)));
      chk("rco_sat",  int'(rco1), int'(ent && is_term(m1)));
      model(1'b0, m0, s0, n0, ns0, f0);
      model(1'b1, m1, s1, n1, ns1, f1);
      m0 = n0; s0 = ns0; m1 = n1; s1 = ns1;
      e.q0 = n0; e.f0 = int'(f0); e.q1 = n1; e.f1 = int'(f1);
      sb.push_back(e);
   endtask

   task automatic cnt(input bit dr, input int lim, input int cycles);
      for (int i = 0; i < cycles; i++) step(1, 1, 1, 1, dr, lim, 0);
   endtask

   // monitor: the counter presents a new value after every edge
   always @(posedge clock) begin
      exp_t e;
      #1;
      if (!reset && sb.size() > 0) begin
         e = sb.pop_front();
         chk("q_wrap",   int'(q0),   e.q0);
         chk("fim_wrap", int'(fim0), e.f0);
         chk("q_sat",    int'(q1),   e.q1);
         chk("fim_sat",  int'(fim1), e.f1);
      end
   end

   initial begin
      #2;
      chk("reset_q_wrap", int'(q0), 0);
      chk("reset_q_sat",  int'(q1), 0);
      chk("reset_fim",    int'(fim0 | fim1), 0);
      limite = N'(0); dir = 1'b0; ent = 1'b1;
      #1;
      chk("reset_rco_lim0", int'(rco0), 1);
      limite = N'(4);
      #1;
      chk("reset_rco_lim4", int'(rco0), 0);
      @(negedge clock);
      reset = 1'b0;

      // up count, wrap at limite=4 (saturating copy parks at 4)
      cnt(0, 4, 3);
      step(1, 1, 1, 0, 0, 4, 0); step(1, 1, 1, 0, 0, 4, 0); step(1, 1, 1, 0, 0, 4, 0);
      cnt(0, 4, 2);
      step(1, 1, 0, 1, 0, 4, 0);
      cnt(0, 4, 4);
      // saturate at 3 then count down to 0
      step(0, 1, 1, 1, 0, 3, 0);
      cnt(0, 3, 6);
      cnt(1, 3, 5);
      // load 1, count down with wrap to 9
      step(1, 0, 1, 1, 1, 9, 1);
      cnt(1, 9, 4);
      // clear beats load; load out of range then count
      step(1, 0, 1, 1, 0, 9, 5);
      step(0, 0, 1, 1, 0, 9, 5);
      step(1, 0, 1, 1, 0, 4, 20);
      cnt(0, 4, 3);
      // consecutive wraps with limite=0
      cnt(0, 0, 3);

      // async reset between edges at Q=7
      step(1, 0, 1, 1, 0, 12, 7);
      @(posedge clock);
      #2 reset = 1'b1;
      #1;
      chk("async_q_wrap", int'(q0), 0);
      chk("async_q_sat",  int'(q1), 0);
      chk("async_fim",    int'(fim0 | fim1), 0);
      #1 reset = 1'b0;
      m0 = 0; m1 = 0; s0 = 0; s1 = 0;
      cnt(0, 12, 3);

      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 99) >= 4, $urandom_range(0, 99) >= 7,
              $urandom_range(0, 99) >= 12, $urandom_range(0, 99) >= 12,
              (i / 25) % 2 == 1 ? ($urandom_range(0, 99) >= 10) : ($urandom_range(0, 99) < 10),
              (i % 40 < 3) ? $urandom_range(0, 2) : $urandom_range(0, 12),
              $urandom_range(0, 20));
      end

      @(posedge clock);
      #3;
      chk("scoreboard_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/contador_163_param.md
Name: contador_163_param

Overview:
- Parametrised successor of the 74163-style counter used in the game datapath for timeouts, sequence position and round limits.
- Adds generic width, a runtime-programmable terminal value, up/down direction, a wrap or saturate mode and a registered one-cycle end pulse.
- Keeps the 163 control set: synchronous clear, synchronous load, and the ENT/ENP enables.
- Drop-in for timers and sequence counters in the game control units. The D width now matches Q.

Parameters:
- N, 16, counter width in bits (Q, D, limite).
- SATURA, 0, terminal-count mode: 0 = wrap around, 1 = hold at terminal value.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous reset, active-high.
- clr  in  1  synchronous clear, active-low.
- ld  in  1  synchronous load, active-low.
- ent  in  1  count enable; also gates rco.
- enp  in  1  count enable.
- dir  in  1  0 = count up, 1 = count down.
- limite  in  N  terminal value for counting up (modulus minus 1); wrap target for counting down.
- D  in  N  parallel load data.
- Q  out  N  counter value (registered).
- rco  out  1  ripple carry, combinational.
- fim  out  1  registered one-cycle end-of-count pulse.

Behaviour:
- Clocking and reset: one clock (clock). reset is asynchronous and active-high.
- Reset values: Q = 0, fim = 0, internal saturado flag = 0.
- Terminal condition term:
  - dir=0: term = (Q >= limite). The >= covers a loaded value above limite.
  - dir=1: term = (Q == 0).
- rco = ent && term, combinational, no clock latency.
  - Directly after reset with ent=1: rco = 1 if dir=1, or if dir=0 and limite=0.
- Count step: cen = ent && enp.
- Register priority on each rising edge, first match wins:
  1. reset (asynchronous, overrides everything).
  2. clr=0: Q <= 0; fim <= 0; saturado <= 0.
  3. ld=0: Q <= D, D may be out of range; fim <= 0; saturado <= 0.
  4. cen=1 and term=0: Q <= Q+1 (dir=0) or Q-1 (dir=1); fim <= 0; saturado <= 0.
  5. cen=1 and term=1, SATURA=0:
     - Q <= 0 (dir=0) or Q <= limite (dir=1).
     - fim <= 1.
  6. cen=1 and term=1, SATURA=1:
     - Q holds.
     - fim <= ~saturado, so the pulse fires only on the first saturating step.
     - saturado <= 1.
  7. Otherwise, hold: Q holds; fim <= 0; saturado <= saturado & term.
- fim latency:
  - fim is high for exactly one cycle after the edge on which the terminal step occurred.
  - It never stays high two consecutive cycles unless consecutive wrap steps occur (limite=0, SATURA=0).
- limite changes: take effect immediately in term and rco. No state is held on limite.
- dir toggles mid-count: the next step uses the new direction. saturado clears once term goes false.
- Arithmetic: N-bit unsigned. Wrap is explicit per rules 5–6, with no reliance on natural overflow. Q-1 is never evaluated at Q=0 because term catches it.
- Reset asserted mid-count: Q, fim and saturado clear immediately, with no clock needed. Counting resumes on the first edge after reset deasserts.

Test Plan:
1. N=16, SATURA=0, limite=4, dir=0, ent=enp=1, from reset:
   - Q goes 0,1,2,3,4,0,1.
   - rco=1 only while Q=4.
   - fim=1 only in the cycle where Q=0 following 4.
2. Same setup, enp=0 at Q=2 for 3 cycles:
   - Q holds at 2; fim=0.
   - With ent=0 at Q=4, rco=0.
3. SATURA=1, limite=3, dir=0, count enabled:
   - Q goes 0,1,2,3,3,3.
   - fim pulses once, on the cycle after the first step attempted at 3.
   - Then dir=1: Q goes 2,1,0,0; fim pulses once at the first saturation at 0.
4. SATURA=0, dir=1, limite=9, ld=0 with D=1, then count:
   - Q goes 1,0,9,8.
   - rco=1 at Q=0; fim=1 in the cycle where Q=9.
5. Priority and out-of-range:
   - clr=0 and ld=0 together with Q=5 → Q=0.
   - Load D=20 with limite=4, dir=0, then count → next Q=0, fim=1.
6. Async reset pulse mid-edge-interval at Q=7:
   - Q=0 and fim=0 before the next clock.
   - After release, counting resumes from 0.
